// File: rtl/sqrt_float_pkg.sv
// rtl/sqrt_float_pkg.sv - shared widths, constants, FSM states and gain helpers for sqrt_float_cordic
// Purpose: field widths, IEEE-754 special encodings, the hyperbolic CORDIC
//          repeat schedule and the 1/K_h gain-correction constant.
// Ports:   none (package).
package sqrt_float_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int FIX_W  = 30;   // Q2.28 working precision
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN_NEG = 32'hFFC00000;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] PINF     = 32'h7F800000;

  localparam int NUM_ITER_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_PREP  = 3'd2,
    ST_ITER  = 3'd3,
    ST_PACK  = 3'd4
  } state_e;

  // Hyperbolic CORDIC only converges if these indices run twice.
  function automatic logic is_rep(input int i);
    return (i == 4) || (i == 13) || (i == 40);
  endfunction

  // 1/K_h in Q1.28 for iterations 1..n including repeats.
  // K_h^2 is accumulated in Q0.62, inverted by long division, then square-rooted.
  function automatic logic [28:0] inv_kh_f(input int n);
    logic [63:0] kh2, r, q, num, res, bt;
    kh2 = 64'h4000_0000_0000_0000;
    for (int i = 1; i <= n; i++) begin
      kh2 = kh2 - (kh2 >> (2 * i));
      if (is_rep(i)) kh2 = kh2 - (kh2 >> (2 * i));
    end
    // q = 2^118 / kh2 = (1/K_h^2) scaled by 2^56
    r = 64'd0;
    q = 64'd0;
    for (int b = 0; b < 119; b++) begin
      r = {r[62:0], (b == 0)};
      q = {q[62:0], 1'b0};
      if (r >= kh2) begin
        r    = r - kh2;
        q[0] = 1'b1;
      end
    end
    num = q;
    res = 64'd0;
    bt  = 64'h4000_0000_0000_0000;
    for (int k = 0; k < 32; k++) begin
      if (num >= res + bt) begin
        num = num - (res + bt);
        res = (res >> 1) + bt;
      end else begin
        res = res >> 1;
      end
      bt = bt >> 2;
    end
    return 29'(res);
  endfunction

  localparam logic [28:0] INV_KH = inv_kh_f(NUM_ITER_DEF);

endpackage

// File: rtl/cordic_hyp_vec_stage.sv
// rtl/cordic_hyp_vec_stage.sv - one hyperbolic vectoring micro-rotation
// Purpose: combinational shift/add-subtract driving y toward zero, d = -sign(y).
// Ports:   x_in, y_in - current vector (signed fixed point)
//          shift      - iteration index i
//          x_out, y_out - rotated vector
module cordic_hyp_vec_stage #(
  parameter int W = 31
) (
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic        [5:0]   shift,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out
);

  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;

  always_comb begin
    xs = x_in >>> shift;
    ys = y_in >>> shift;
    if (y_in[W-1]) begin
      x_out = x_in + ys;
      y_out = y_in + xs;
    end else begin
      x_out = x_in - ys;
      y_out = y_in - xs;
    end
  end

endmodule

// File: rtl/sqrt_float_cordic.sv
// rtl/sqrt_float_cordic.sv - IEEE-754 single square root via hyperbolic vectoring CORDIC
// Purpose: multi-cycle sqrt with start/done handshake; specials resolved in CHECK.
//          Define SQRT_FLOAT_RNE_EN for round-to-nearest-even, otherwise truncation.
// Ports:   clk      - clock, rising edge
//          rst      - asynchronous active-low reset
//          start    - request, sampled in IDLE only
//          u        - operand, captured on accepted start
//          out      - result, held until the next result
//          done     - one-cycle pulse while out is fresh (PACK state)
//          neg_flag - operand was negative non-zero
module sqrt_float_cordic
  import sqrt_float_pkg::*;
#(
  parameter int NUM_ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] u,
  output logic [31:0] out,
  output logic        done,
  output logic        neg_flag
);

  localparam int                   IW       = FIX_W + 1;  // extra sign bit
  localparam logic [28:0]          INV_KH_P = inv_kh_f(NUM_ITER);
  localparam logic [5:0]           LAST_IDX = 6'(NUM_ITER);
  localparam logic signed [IW-1:0] QUARTER  = 31'sd67108864;  // 0.25 in Q2.28

  state_e                state_q, state_d;
  logic [31:0]           u_q, u_d;
  logic signed [IW-1:0]  x_q, x_d, y_q, y_d;
  logic [5:0]            idx_q, idx_d;
  logic                  rep_q, rep_d;
  logic [EXP_W-1:0]      rexp_q, rexp_d;
  logic [31:0]           out_q, out_d;
  logic                  done_q, done_d;
  logic                  neg_q, neg_d;

  logic [EXP_W-1:0]      u_exp;
  logic [FRAC_W-1:0]     u_frac;
  logic                  special, spec_neg;
  logic [31:0]           spec_res;

  always_comb begin
    u_exp    = u_q[30:23];
    u_frac   = u_q[22:0];
    special  = 1'b1;
    spec_neg = 1'b0;
    spec_res = PINF;
    if (u_exp == 8'hFF && u_frac != '0) begin
      spec_res = QNAN;
    end else if (u_exp == 8'h00 && u_frac == '0) begin
      spec_res = u_q;
    end else if (u_q[31]) begin
      spec_res = QNAN_NEG;
      spec_neg = 1'b1;
    end else if (u_exp != 8'hFF) begin
      special = 1'b0;
    end
  end

  // Normalise to m in [1,2), then fold an odd exponent into m so e/2 is exact.
  logic [4:0]            lzc;
  logic [23:0]           sig;
  logic signed [9:0]     e_raw, e_even, e_half;
  logic signed [IW-1:0]  m_fix;
  logic [EXP_W-1:0]      rexp_new;

  always_comb begin
    lzc = 5'd0;
    for (int b = 0; b < FRAC_W; b++) begin
      if (u_frac[b]) lzc = 5'(22 - b);
    end
    if (u_exp == 8'h00) begin
      sig   = 24'({1'b0, u_frac} << (lzc + 5'd1));
      e_raw = -10'sd127 - $signed({5'b0, lzc});
    end else begin
      sig   = {1'b1, u_frac};
      e_raw = $signed({2'b00, u_exp}) - 10'sd127;
    end
    e_even   = e_raw + $signed({9'b0, e_raw[0]});
    e_half   = e_even >>> 1;
    rexp_new = 8'(e_half + 10'sd127);
    m_fix    = IW'(sig) << (e_raw[0] ? 4 : 5);
  end

  logic signed [IW-1:0] x_nx, y_nx;

  cordic_hyp_vec_stage #(.W(IW)) u_stage (
    .x_in  (x_q),
    .y_in  (y_q),
    .shift (idx_q),
    .x_out (x_nx),
    .y_out (y_nx)
  );

  logic                  rep_now, last_iter;
  assign rep_now   = is_rep(int'(idx_q));
  assign last_iter = (idx_q == LAST_IDX) && (!rep_now || rep_q);

  // Gain correction and renormalisation of the final x; sqrt(m) lies in [0.707,1.415).
  logic                  hi;
  logic [FRAC_W-1:0]     frac_t;
  logic [EXP_W-1:0]      exp_t;
  logic [31:0]           pack_res;

`ifdef SQRT_FLOAT_RNE_EN
  logic [56:0]           prod;
  logic                  guard, sticky, round_up;
  always_comb begin
    prod     = 57'(x_nx[FIX_W-1:0]) * 57'(INV_KH_P);
    hi       = prod[56];
    frac_t   = hi ? prod[55:33] : prod[54:32];
    guard    = hi ? prod[32]    : prod[31];
    sticky   = hi ? |prod[31:0] : |prod[30:0];
    exp_t    = hi ? rexp_q : 8'(rexp_q - 8'd1);
    round_up = guard & (sticky | frac_t[0]);
    // A mantissa carry ripples into the exponent field.
    pack_res = {1'b0, exp_t, frac_t} + {31'b0, round_up};
  end
`else
  logic [24:0]           prod_top;
  always_comb begin
    prod_top = 25'((57'(x_nx[FIX_W-1:0]) * 57'(INV_KH_P)) >> 32);
    hi       = prod_top[24];
    frac_t   = hi ? prod_top[23:1] : prod_top[22:0];
    exp_t    = hi ? rexp_q : 8'(rexp_q - 8'd1);
    pack_res = {1'b0, exp_t, frac_t};
  end
`endif

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    rexp_d  = rexp_q;
    out_d   = out_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          u_d     = u;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (special) begin
          out_d   = spec_res;
          neg_d   = spec_neg;
          done_d  = 1'b1;
          state_d = ST_PACK;
        end else begin
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        x_d     = m_fix + QUARTER;
        y_d     = m_fix - QUARTER;
        rexp_d  = rexp_new;
        idx_d   = 6'd1;
        rep_d   = 1'b0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        x_d = x_nx;
        y_d = y_nx;
        if (last_iter) begin
          out_d   = pack_res;
          neg_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_PACK;
        end else if (rep_now && !rep_q) begin
          rep_d = 1'b1;
        end else begin
          rep_d = 1'b0;
          idx_d = idx_q + 6'd1;
        end
      end
      ST_PACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      u_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      rep_q   <= 1'b0;
      rexp_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      rexp_q  <= rexp_d;
      out_q   <= out_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
    end
  end

  assign out      = out_q;
  assign done     = done_q;
  assign neg_flag = neg_q;

endmodule

// File: tb/tb_sqrt_float_cordic.sv
// tb/tb_sqrt_float_cordic.sv - self-checking bench for sqrt_float_cordic
module tb_sqrt_float_cordic;

  localparam int  NUM_ITER = 16;
  localparam real TOL      = 2.0 ** (-(NUM_ITER - 2));

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] u = 32'h0;
  logic [31:0] out;
  logic        done;
  logic        neg_flag;

  int n_total = 0;
  int n_pass  = 0;

  sqrt_float_cordic #(.NUM_ITER(NUM_ITER)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .u        (u),
    .out      (out),
    .done     (done),
    .neg_flag (neg_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic real f2r(input logic [31:0] b);
    int  ex;
    real mag;
    ex = int'(b[30:23]);
    if (ex == 0) mag = real'(int'(b[22:0])) * (2.0 ** (-149));
    else         mag = (1.0 + real'(int'(b[22:0])) / 8388608.0) * (2.0 ** (ex - 127));
    return b[31] ? -mag : mag;
  endfunction

  // Reference: IEEE class rules for specials, real sqrt for everything else.
  task automatic model(input logic [31:0] a, output bit sp, output logic [31:0] eb,
                       output logic en, output real refv, output int lat);
    int reps;
    reps = 0;
    if (4 <= NUM_ITER)  reps++;
    if (13 <= NUM_ITER) reps++;
    if (40 <= NUM_ITER) reps++;
    sp = 1'b1; en = 1'b0; eb = 32'h0; refv = 0.0;
    if (a[30:23] == 8'hFF && a[22:0] != 0)      eb = 32'h7FC00000;
    else if (a[30:0] == 0)                      eb = a;
    else if (a[31]) begin eb = 32'hFFC00000; en = 1'b1; end
    else if (a[30:23] == 8'hFF)                 eb = 32'h7F800000;
    else begin sp = 1'b0; refv = $sqrt(f2r(a)); end
    lat = sp ? 2 : 3 + NUM_ITER + reps;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a);
    bit          sp, ok;
    logic [31:0] eb, res;
    logic        en, rneg;
    real         refv, got, err;
    int          elat, lat;
    model(a, sp, eb, en, refv, elat);
    @(negedge clk);
    u = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = out; rneg = neg_flag;
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    if (sp) begin
      chk({tag, " out"}, res, eb);
    end else begin
      got = f2r(res);
      err = (got > refv) ? got - refv : refv - got;
      ok  = (res[31] == 1'b0) && (err <= refv * TOL);
      n_total++;
      assert (ok) n_pass++;
      else $error("FAIL %s out: observed %h (%g) expected %g rel tol %g", tag, res, got, refv, TOL);
    end
    chk({tag, " neg_flag"}, 32'(rneg), 32'(en));
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'h0);
  endtask

  logic [31:0] dir_vec [16] = '{
    32'h40800000, 32'h40000000, 32'h3F000000, 32'h3DCCCCCD,
    32'hBF800001, 32'hC44B1AF7, 32'h80000001, 32'hFF800000,
    32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
    32'hFFC00001, 32'h00000001, 32'h3F800001, 32'h7F7FFFFF
  };

  initial begin
    int dones;
    #1;
    chk("reset out", out, 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset neg_flag", 32'(neg_flag), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    foreach (dir_vec[i]) do_op($sformatf("dir%0d", i), dir_vec[i]);

    for (int i = 0; i < 16; i++) do_op("rnd_any", $urandom());
    for (int i = 0; i < 16; i++)
      do_op("rnd_pos", {1'b0, 8'($urandom_range(1, 254)), 23'($urandom())});
    for (int i = 0; i < 6; i++) do_op("rnd_sub", {9'b0, 23'($urandom())});

    // Asynchronous reset in the middle of the iterations.
    do_op("pre_rst", 32'hBF800000);
    @(negedge clk);
    u = 32'h40800000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst out", out, 32'h0);
    chk("midrst done", 32'(done), 32'h0);
    chk("midrst neg_flag", 32'(neg_flag), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst idle", 32'(dones), 32'h0);
    do_op("post_rst", 32'h40800000);

    // start held for two cycles launches exactly one operation.
    @(negedge clk);
    u = 32'h41100000; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("hold2 dones", 32'(dones), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
